duty_integrator: RTL and testbench
==================================

# duty_integrator

Digital integral compensator placed directly downstream of the ADC error encoder in the buck control loop. It consumes the encoder's 4-bit two's-complement error step (-4..+4) and produces the duty-cycle command for the multi-phase DPWM. A soft-start ramp runs first, then the block accumulates error steps at a fixed update cadence with hard saturation.

## Interface
- DUTY_W, 8: width of duty command.
- DUTY_MAX, 240: upper clamp of duty (≤ 2^DUTY_W−1).
- DUTY_MIN, 0: lower clamp of duty.
- UPDATE_DIV, 16: clk cycles between regulation updates (≥2).
- SS_DIV, 64: clk cycles between soft-start increments (≥2).
- SS_STEP, 1: duty increment per soft-start tick.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  converter run request; level-sensitive.
- err_i  in  4  signed error step from encoder (positive = raise duty).
- duty  out  DUTY_W  registered duty command to DPWM.
- update  out  1  one-cycle pulse, high in the cycle duty takes a new value.
- sat_hi  out  1  last regulation update was clamped at DUTY_MAX.
- sat_lo  out  1  last regulation update was clamped at DUTY_MIN.
- state  out  2  FSM state: 00 IDLE, 01 SOFTSTART, 10 REGULATE.

## Operation
- One clock; reset is asynchronous and active-low. On reset: duty=0, update=0, sat_hi=0, sat_lo=0, state=IDLE, all counters 0.
- Single tick counter `cnt`; terminal value SS_DIV−1 in SOFTSTART, UPDATE_DIV−1 in REGULATE; cleared on every state change.
- IDLE: duty=0, cnt held 0. enable=1 → SOFTSTART next edge.
- SOFTSTART, at terminal count:
  - err_i ≤ 0 (sign bit set or zero): → REGULATE, duty unchanged, no update pulse.
  - else duty ← min(duty+SS_STEP, DUTY_MAX), update=1; if the result equals DUTY_MAX → REGULATE.
- REGULATE, at terminal count: sum = duty + sext(err_i), computed in DUTY_W+2 signed bits.
  - sum > DUTY_MAX → duty=DUTY_MAX, sat_hi=1, sat_lo=0.
  - sum < DUTY_MIN → duty=DUTY_MIN, sat_lo=1, sat_hi=0.
  - else duty=sum, both flags 0.
  - update=1 on every regulation tick, including err_i=0 and clamped ticks.
- All 16 err_i codes are interpreted as two's complement (-8..+7); out-of-range codes are clamped only through the duty saturation.
- enable=0 in any state → IDLE next edge: duty=0, sat flags cleared, update=0, cnt=0. This overrides a coincident terminal count.
- sat flags change only on regulation ticks or when returning to IDLE.

## Timing
- err_i is sampled only on the rising edge that ends a terminal-count cycle. The new duty and the update pulse appear together after that edge; latency is 1 clk.
- Regulation cadence: one update every UPDATE_DIV cycles. The first REGULATE update comes UPDATE_DIV cycles after entering REGULATE.
- Soft-start: the first increment comes SS_DIV cycles after entering SOFTSTART.
- Soft-start time from enable to reaching DUTY_MAX with err_i held positive: 1 + SS_DIV·ceil(DUTY_MAX/SS_STEP) cycles.
- update is never high for two consecutive cycles.
- Reset assertion mid-operation forces reset values immediately, independent of clk. Deassertion is synchronous to the next clk edge via the external reset synchronizer.

## Test plan
- Reset/idle: assert rst_n=0 mid-REGULATE with duty=100 → duty=0, update=0, flags 0, state=00 immediately; hold enable=0 → duty stays 0.
- Soft-start ramp: enable=1, err_i=+4, SS_DIV=64 → duty increments 0,1,2… every 64 cycles with one update pulse each. Drive err_i=0 at the tick where duty=20 → state=10, duty stays 20, no pulse.
- Regulation arithmetic: in REGULATE with duty=100, apply err_i=+3, −4 (4'b1100), 0 on successive ticks → duty 103, 99, 99. Pulses spaced exactly 16 cycles apart.
- Upper clamp: duty=238, err_i=+4 → duty=240, sat_hi=1. Next tick err_i=−1 → duty=239, sat_hi=0.
- Lower clamp: duty=2, err_i=−4 → duty=0, sat_lo=1. Out-of-range code 4'b1000 (−8) at duty=5 → duty=0, sat_lo=1.
- Disable collision: deassert enable on the same cycle as a regulation terminal count → next edge state=IDLE, duty=0, update=0. Re-enable → soft-start restarts from duty=0.

Source files
------------

// File: rtl/duty_integrator.sv
// duty_integrator: soft-start ramp followed by saturating integral regulation of the DPWM duty command.
// err_i is a 4-bit two's-complement step sampled only on terminal-count edges.
module duty_integrator #(
    parameter int DUTY_W     = 8,
    parameter int DUTY_MAX   = 240,
    parameter int DUTY_MIN   = 0,
    parameter int UPDATE_DIV = 16,
    parameter int SS_DIV     = 64,
    parameter int SS_STEP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [3:0]        err_i,
    output logic [DUTY_W-1:0] duty,
    output logic              update,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic [1:0]        state
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] SOFT = 2'b01;
    localparam logic [1:0] REG  = 2'b10;
    localparam int CNT_TOP = (SS_DIV > UPDATE_DIV) ? SS_DIV : UPDATE_DIV;
    localparam int CNT_W   = $clog2(CNT_TOP);
    localparam logic signed [DUTY_W+1:0] MAX_S = (DUTY_W+2)'(DUTY_MAX);
    localparam logic signed [DUTY_W+1:0] MIN_S = (DUTY_W+2)'(DUTY_MIN);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DUTY_W-1:0]       duty_q, duty_d;
    logic                    update_q, update_d;
    logic                    sat_hi_q, sat_hi_d;
    logic                    sat_lo_q, sat_lo_d;
    logic                    term;
    logic [DUTY_W+1:0]       inc;
    logic [DUTY_W-1:0]       ss_val;
    logic signed [DUTY_W+1:0] sum;

    assign term   = (state_q == SOFT) ? (cnt_q == CNT_W'(SS_DIV - 1)) : (cnt_q == CNT_W'(UPDATE_DIV - 1));
    assign inc    = {2'b00, duty_q} + (DUTY_W+2)'(SS_STEP);
    assign ss_val = (inc > MAX_S) ? DUTY_W'(DUTY_MAX) : inc[DUTY_W-1:0];
    // Sign-extended error added in two extra bits so both clamps see the true sum
    assign sum    = signed'({2'b00, duty_q}) + signed'({{(DUTY_W-2){err_i[3]}}, err_i});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        duty_d   = duty_q;
        update_d = 1'b0;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;
        if (!enable || state_q == 2'b11) begin
            state_d  = IDLE;
            cnt_d    = '0;
            duty_d   = '0;
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = SOFT;
            cnt_d   = '0;
        end else if (term) begin
            cnt_d = '0;
            if (state_q == SOFT) begin
                if (err_i[3] || err_i == 4'd0) begin
                    state_d = REG;
                end else begin
                    duty_d   = ss_val;
                    update_d = 1'b1;
                    state_d  = (ss_val == DUTY_W'(DUTY_MAX)) ? REG : SOFT;
                end
            end else begin
                update_d = 1'b1;
                sat_hi_d = sum > MAX_S;
                sat_lo_d = sum < MIN_S;
                duty_d   = (sum > MAX_S) ? DUTY_W'(DUTY_MAX) :
                           (sum < MIN_S) ? DUTY_W'(DUTY_MIN) : sum[DUTY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            duty_q   <= '0;
            update_q <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            update_q <= update_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
        end
    end

    assign duty   = duty_q;
    assign update = update_q;
    assign sat_hi = sat_hi_q;
    assign sat_lo = sat_lo_q;
    assign state  = state_q;
endmodule

// File: tb/tb_duty_integrator.sv
// tb_duty_integrator: directed scenarios for soft-start, regulation, clamps, disable and async reset.
module tb_duty_integrator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] err_i = 4'd0;
    logic [7:0] duty;
    logic       update, sat_hi, sat_lo;
    logic [1:0] state;
    int checks = 0;
    int errors = 0;

    duty_integrator dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .err_i(err_i),
        .duty(duty), .update(update), .sat_hi(sat_hi), .sat_lo(sat_lo), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full regulation period; the pulse must land on the 16th edge only
    task automatic reg_step(input logic [3:0] e, input int exp_d, input logic eh, input logic el);
        err_i = e;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            checks++;
            if (update !== (i == 16)) begin
                errors++;
                $display("FAIL reg_pulse cycle %0d: got %b want %b", i, update, (i == 16));
            end
        end
        checks++;
        if (duty !== 8'(exp_d)) begin
            errors++;
            $display("FAIL reg_duty err=%h: got %0d want %0d", e, duty, exp_d);
        end
        checks++;
        if ({sat_hi, sat_lo} !== {eh, el}) begin
            errors++;
            $display("FAIL reg_flags err=%h: got %b%b want %b%b", e, sat_hi, sat_lo, eh, el);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({duty, update, sat_hi, sat_lo, state} !== 13'd0) begin
            errors++;
            $display("FAIL reset_values: got duty=%0d upd=%b hi=%b lo=%b st=%b want all 0", duty, update, sat_hi, sat_lo, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (duty !== 8'd0 || state !== 2'b00) begin
            errors++;
            $display("FAIL idle_hold: got duty=%0d st=%b want 0 00", duty, state);
        end
    endtask

    task automatic test_softstart;
        int pulses = 0;
        enable = 1'b1;
        err_i = 4'd4;
        tick(1);
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL ss_enter: got %b want 01", state);
        end
        tick(63);
        checks++;
        if (duty !== 8'd0 || update !== 1'b0) begin
            errors++;
            $display("FAIL ss_pre_tick: got duty=%0d upd=%b want 0 0", duty, update);
        end
        tick(1);
        checks++;
        if (duty !== 8'd1 || update !== 1'b1) begin
            errors++;
            $display("FAIL ss_first_inc: got duty=%0d upd=%b want 1 1", duty, update);
        end
        for (int i = 0; i < 19 * 64; i++) begin
            tick(1);
            pulses += update;
        end
        checks++;
        if (pulses !== 19 || duty !== 8'd20) begin
            errors++;
            $display("FAIL ss_ramp: got pulses=%0d duty=%0d want 19 20", pulses, duty);
        end
        err_i = 4'd0;
        tick(64);
        checks++;
        if (state !== 2'b10 || duty !== 8'd20 || update !== 1'b0) begin
            errors++;
            $display("FAIL ss_exit: got st=%b duty=%0d upd=%b want 10 20 0", state, duty, update);
        end
    endtask

    task automatic test_regulate;
        for (int d = 24; d <= 100; d += 4) reg_step(4'd4, d, 1'b0, 1'b0);
        reg_step(4'd3, 103, 1'b0, 1'b0);
        reg_step(4'hC, 99, 1'b0, 1'b0);
        reg_step(4'd0, 99, 1'b0, 1'b0);
    endtask

    task automatic test_clamp_hi;
        for (int d = 103; d <= 235; d += 4) reg_step(4'd4, d, 1'b0, 1'b0);
        reg_step(4'd3, 238, 1'b0, 1'b0);
        reg_step(4'd4, 240, 1'b1, 1'b0);
        reg_step(4'hF, 239, 1'b0, 1'b0);
    endtask

    task automatic test_clamp_lo;
        for (int d = 231; d >= 7; d -= 8) reg_step(4'h8, d, 1'b0, 1'b0);
        reg_step(4'hB, 2, 1'b0, 1'b0);
        reg_step(4'hC, 0, 1'b0, 1'b1);
        reg_step(4'd4, 4, 1'b0, 1'b0);
        reg_step(4'd1, 5, 1'b0, 1'b0);
        reg_step(4'h8, 0, 1'b0, 1'b1);
    endtask

    task automatic test_disable;
        err_i = 4'd4;
        tick(15);
        enable = 1'b0;
        tick(1);
        checks++;
        if (state !== 2'b00 || duty !== 8'd0 || update !== 1'b0 || sat_lo !== 1'b0) begin
            errors++;
            $display("FAIL disable_collision: got st=%b duty=%0d upd=%b lo=%b want 00 0 0 0", state, duty, update, sat_lo);
        end
        tick(5);
        checks++;
        if (duty !== 8'd0 || state !== 2'b00) begin
            errors++;
            $display("FAIL disable_hold: got duty=%0d st=%b want 0 00", duty, state);
        end
        enable = 1'b1;
        tick(1);
        checks++;
        if (state !== 2'b01 || duty !== 8'd0) begin
            errors++;
            $display("FAIL reenable: got st=%b duty=%0d want 01 0", state, duty);
        end
        tick(64);
        checks++;
        if (duty !== 8'd1 || update !== 1'b1) begin
            errors++;
            $display("FAIL restart_inc: got duty=%0d upd=%b want 1 1", duty, update);
        end
    endtask

    task automatic test_ss_max;
        tick(64 * 239 - 1);
        checks++;
        if (duty !== 8'd239 || state !== 2'b01) begin
            errors++;
            $display("FAIL ss_near_max: got duty=%0d st=%b want 239 01", duty, state);
        end
        tick(1);
        checks++;
        if (duty !== 8'd240 || update !== 1'b1 || state !== 2'b10 || sat_hi !== 1'b0) begin
            errors++;
            $display("FAIL ss_max: got duty=%0d upd=%b st=%b hi=%b want 240 1 10 0", duty, update, state, sat_hi);
        end
        for (int d = 232; d >= 104; d -= 8) reg_step(4'h8, d, 1'b0, 1'b0);
        reg_step(4'hC, 100, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({duty, update, sat_hi, sat_lo, state} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got duty=%0d upd=%b hi=%b lo=%b st=%b want all 0", duty, update, sat_hi, sat_lo, state);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        checks++;
        if (duty !== 8'd0 || state !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle: got duty=%0d st=%b want 0 00", duty, state);
        end
    endtask

    initial begin
        test_reset;
        test_softstart;
        test_regulate;
        test_clamp_hi;
        test_clamp_lo;
        test_disable;
        test_ss_max;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
